pipe_ctrl: RTL
==============

# pipe_ctrl

Issue sequencer for the 17-bit-instruction pipeline. Walks a program in instruction memory from address 0 and presents one instruction per cycle to the decode stage. Detects read-after-write hazards against the two younger in-flight instructions and inserts bubbles until they clear. Sits between the instruction ROM and the decode stage and owns the program counter, start/done handshake and stall accounting.

## Interface
Parameters:
- INST_LEN, 17, instruction width: [16:15] ALU op, [14:10] oper1, [9:5] oper2, [4:0] dest
- ADDR_LEN, 5, register address width
- MEM_SIZE, 32, instruction memory depth in words
- PC_LEN, 6, program counter / length width; must hold MEM_SIZE
- CNT_LEN, 16, stall counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled in IDLE only
- prog_len  in  PC_LEN  instructions to issue, 0..MEM_SIZE; captured on accepted start
- imem_addr  out  PC_LEN-1  instruction ROM address (combinational-read ROM)
- imem_data  in  INST_LEN  ROM word at imem_addr, same cycle
- id_inst  out  INST_LEN  instruction to decode stage
- id_valid  out  1  id_inst is a real instruction; 0 = bubble
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at program completion
- stall_cnt  out  CNT_LEN  bubbles inserted during the current/last run
- fwd_a, fwd_b  out  2  forwarding selects for oper1/oper2; only with PIPE_CTRL_FWD_EN

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → capture prog_len into len_q, pc←0, stall_cnt←0. Go to RUN, or to DONE if prog_len=0.
- RUN: imem_addr=pc[PC_LEN-2:0]. Compare imem_data oper1/oper2 against the dest of slot1 (issued last cycle) and slot2 (issued two cycles ago). A valid slot that matches is a hazard.
  - No hazard: id_inst←imem_data, id_valid←1, pc←pc+1.
  - Hazard: id_valid←0, id_inst holds, pc holds, stall_cnt+1.
  - stall_cnt saturates at all-ones.
  - pc+1 == len_q on issue → DRAIN.
- Scoreboard: slot1←{id_valid_next, dest}, slot2←slot1 every cycle. Bubbles shift in valid=0.
- DRAIN: id_valid←0 for 2 cycles (counter), then DONE. All hazard windows have closed by then.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. No abort; only rst_n stops a run.
- Hazard matching uses all 32 register addresses; there is no hard-wired zero register.
- Both sources matching: one stall decision. Matches in slot1 and slot2 are the same hazard.

## Timing
- Reset values: id_inst=0, id_valid=0, busy=0, done=0, stall_cnt=0, fwd_a=fwd_b=0, pc=0, state IDLE, slots invalid.
- start at edge N → first id_valid=1 at edge N+1 (no hazard) → busy=1 from N+1.
- Dependent adjacent pair without forwarding: 2 bubbles. Distance-2 dependency: 1 bubble.
- Hazard-free run of L instructions: done pulses L+3 cycles after start is accepted.
- prog_len=0: done one cycle after start; busy never rises.
- prog_len>MEM_SIZE is clamped to MEM_SIZE.
- rst_n low mid-run: immediate return to reset values; stall_cnt is lost.

## Configuration
- PIPE_CTRL_FWD_EN defined:
  - The hazard check is removed and no bubbles are ever inserted; stall_cnt stays 0.
  - fwd_a/fwd_b register alongside id_inst: 01 = source matches slot1 dest (EX result), 10 = matches slot2 dest only (WB value), 00 = register file.
  - slot1 has priority when both match.
- Undefined: fwd_a/fwd_b ports are absent; stall behaviour is as in Operation.

## Structure
- Shared package pipe_pkg holds:
  - field position constants: OP_HI/OP_LO, SRC1_HI/LO, SRC2_HI/LO, DST_HI/LO
  - FWD_RF/FWD_EX/FWD_WB encodings
  - state enum for IDLE/RUN/DRAIN/DONE
- One sub-module: pipe_hazard. Purely combinational source-vs-slot comparator, returns the hazard flag and the forward selects. Used in both configurations.

## Test plan
- Hazard-free 4-instruction program, start at cycle 0 → id_valid high cycles 1–4, pc 0..3, done at cycle 7, stall_cnt=0.
- inst0 dest=3, inst1 oper1=3 (FWD off) → two bubbles after inst0, inst1 issued cycle 4, stall_cnt=2.
- inst0 dest=7, inst2 oper2=7 → one bubble before inst2, stall_cnt=1.
- Same program as scenario 2 with PIPE_CTRL_FWD_EN → no bubbles, inst1 issued with fwd_a=01, fwd_b=00. inst2 oper1=3 issued with fwd_a=10.
- prog_len=0 → done one cycle after start, busy stays 0. start pulsed while busy → ignored, pc unaffected.
- rst_n asserted mid-RUN at pc=2 → all outputs at reset values immediately. Fresh start after release begins at pc=0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared field positions, forward encodings, FSM states   |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_pkg;

    localparam int OP_HI   = 16;
    localparam int OP_LO   = 15;
    localparam int SRC1_HI = 14;
    localparam int SRC1_LO = 10;
    localparam int SRC2_HI = 9;
    localparam int SRC2_LO = 5;
    localparam int DST_HI  = 4;
    localparam int DST_LO  = 0;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_if : control, ROM and decode-stage signals of pipe_ctrl  |
// | fwd_a/fwd_b exist only when PIPE_CTRL_FWD_EN is defined            |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
interface pipe_ctrl_if #(
    parameter int INST_LEN = 17,
    parameter int PC_LEN   = 6,
    parameter int CNT_LEN  = 16
) ();

    logic                start;
    logic [PC_LEN-1:0]   prog_len;
    logic [PC_LEN-2:0]   imem_addr;
    logic [INST_LEN-1:0] imem_data;
    logic [INST_LEN-1:0] id_inst;
    logic                id_valid;
    logic                busy;
    logic                done;
    logic [CNT_LEN-1:0]  stall_cnt;

`ifdef PIPE_CTRL_FWD_EN
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;

    modport master (
        input  start, prog_len, imem_data,
        output imem_addr, id_inst, id_valid, busy, done, stall_cnt, fwd_a, fwd_b
    );
    modport slave (
        output start, prog_len, imem_data,
        input  imem_addr, id_inst, id_valid, busy, done, stall_cnt, fwd_a, fwd_b
    );
`else
    modport master (
        input  start, prog_len, imem_data,
        output imem_addr, id_inst, id_valid, busy, done, stall_cnt
    );
    modport slave (
        output start, prog_len, imem_data,
        input  imem_addr, id_inst, id_valid, busy, done, stall_cnt
    );
`endif

endinterface
`default_nettype wire

// File: rtl/pipe_hazard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard : compares two source registers against in-flight dests|
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_hazard
    import pipe_pkg::*;
#(
    parameter int ADDR_LEN = 5
) (
    input  logic [ADDR_LEN-1:0] i_src1,
    input  logic [ADDR_LEN-1:0] i_src2,
    input  logic                i_slot1_vld,
    input  logic [ADDR_LEN-1:0] i_slot1_dst,
    input  logic                i_slot2_vld,
    input  logic [ADDR_LEN-1:0] i_slot2_dst,
    output logic                o_hazard,
    output logic [1:0]          o_fwd_a,
    output logic [1:0]          o_fwd_b
);

    logic w_a1, w_a2, w_b1, w_b2;

    always_comb begin
        w_a1 = i_slot1_vld && (i_src1 == i_slot1_dst);
        w_a2 = i_slot2_vld && (i_src1 == i_slot2_dst);
        w_b1 = i_slot1_vld && (i_src2 == i_slot1_dst);
        w_b2 = i_slot2_vld && (i_src2 == i_slot2_dst);

        o_hazard = w_a1 | w_a2 | w_b1 | w_b2;

        // The younger producer wins: its value is the architecturally newest
        o_fwd_a = FWD_RF;
        if (w_a1)      o_fwd_a = FWD_EX;
        else if (w_a2) o_fwd_a = FWD_WB;

        o_fwd_b = FWD_RF;
        if (w_b1)      o_fwd_b = FWD_EX;
        else if (w_b2) o_fwd_b = FWD_WB;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl : issue sequencer with RAW hazard stalls                 |
// | Option PIPE_CTRL_FWD_EN : forwarding selects instead of bubbles    |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int INST_LEN = 17,
    parameter int ADDR_LEN = 5,
    parameter int MEM_SIZE = 32,
    parameter int PC_LEN   = 6,
    parameter int CNT_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.master ctrl
);

    state_e              state_q, state_d;
    logic [PC_LEN-1:0]   pc_q, pc_d;
    logic [PC_LEN-1:0]   len_q, len_d;
    logic [INST_LEN-1:0] id_inst_q, id_inst_d;
    logic                id_valid_q, id_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_LEN-1:0]  stall_cnt_q, stall_cnt_d;
    logic                drain_q, drain_d;
    logic                slot1_vld_q, slot1_vld_d;
    logic [ADDR_LEN-1:0] slot1_dst_q, slot1_dst_d;
    logic                slot2_vld_q, slot2_vld_d;
    logic [ADDR_LEN-1:0] slot2_dst_q, slot2_dst_d;

    logic                w_hazard;
    logic                w_stall;
    logic [1:0]          w_fwd_a, w_fwd_b;
    logic [PC_LEN-1:0]   w_pc_inc;

    pipe_hazard #(
        .ADDR_LEN (ADDR_LEN)
    ) u_hazard (
        .i_src1      (ctrl.imem_data[SRC1_HI:SRC1_LO]),
        .i_src2      (ctrl.imem_data[SRC2_HI:SRC2_LO]),
        .i_slot1_vld (slot1_vld_q),
        .i_slot1_dst (slot1_dst_q),
        .i_slot2_vld (slot2_vld_q),
        .i_slot2_dst (slot2_dst_q),
        .o_hazard    (w_hazard),
        .o_fwd_a     (w_fwd_a),
        .o_fwd_b     (w_fwd_b)
    );

`ifdef PIPE_CTRL_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       w_unused_haz;

    assign w_stall      = 1'b0;
    assign w_unused_haz = w_hazard;
    assign ctrl.fwd_a   = fwd_a_q;
    assign ctrl.fwd_b   = fwd_b_q;
`else
    logic       w_unused_fwd;

    assign w_stall      = w_hazard;
    assign w_unused_fwd = ^{w_fwd_a, w_fwd_b};
`endif

    assign w_pc_inc = pc_q + PC_LEN'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = 1'b0;
        done_d      = 1'b0;
        stall_cnt_d = stall_cnt_q;
        drain_d     = drain_q;
        // busy lags the state by one cycle so it rises with the first issue
        busy_d      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
`ifdef PIPE_CTRL_FWD_EN
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ctrl.start) begin
                    len_d       = (ctrl.prog_len > PC_LEN'(MEM_SIZE)) ? PC_LEN'(MEM_SIZE)
                                                                       : ctrl.prog_len;
                    pc_d        = '0;
                    stall_cnt_d = '0;
                    state_d     = (ctrl.prog_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_stall) begin
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_LEN'(1);
                end else begin
                    id_inst_d  = ctrl.imem_data;
                    id_valid_d = 1'b1;
                    pc_d       = w_pc_inc;
`ifdef PIPE_CTRL_FWD_EN
                    fwd_a_d    = w_fwd_a;
                    fwd_b_d    = w_fwd_b;
`endif
                    if (w_pc_inc == len_q) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_DONE;
                    drain_d = 1'b0;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        slot1_vld_d = id_valid_d;
        slot1_dst_d = ctrl.imem_data[DST_HI:DST_LO];
        slot2_vld_d = slot1_vld_q;
        slot2_dst_d = slot1_dst_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            id_inst_q   <= '0;
            id_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stall_cnt_q <= '0;
            drain_q     <= 1'b0;
            slot1_vld_q <= 1'b0;
            slot1_dst_q <= '0;
            slot2_vld_q <= 1'b0;
            slot2_dst_q <= '0;
`ifdef PIPE_CTRL_FWD_EN
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
            drain_q     <= drain_d;
            slot1_vld_q <= slot1_vld_d;
            slot1_dst_q <= slot1_dst_d;
            slot2_vld_q <= slot2_vld_d;
            slot2_dst_q <= slot2_dst_d;
`ifdef PIPE_CTRL_FWD_EN
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
`endif
        end
    end

    assign ctrl.imem_addr = pc_q[PC_LEN-2:0];
    assign ctrl.id_inst   = id_inst_q;
    assign ctrl.id_valid  = id_valid_q;
    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
